// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for mmio_bridge: I/O register offsets, CTRL bit positions
// and the registered read-target encoding.
package mmio_bridge_pkg;

  localparam logic [7:0] MMIO_LED   = 8'h00;
  localparam logic [7:0] MMIO_SEG   = 8'h04;
  localparam logic [7:0] MMIO_SW    = 8'h08;
  localparam logic [7:0] MMIO_CYCLE = 8'h0C;
  localparam logic [7:0] MMIO_LOAD  = 8'h10;
  localparam logic [7:0] MMIO_CTRL  = 8'h14;
  localparam logic [7:0] MMIO_VALUE = 8'h18;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_EXPIRED    = 2;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_e;

endpackage

// File: rtl/mmio_bridge_timer.sv
// mmio_bridge_timer: LOAD/VALUE/CTRL down-counter with sticky expired flag.
// Compiled only when MMIO_TIMER_EN is defined.
`ifdef MMIO_TIMER_EN
module mmio_bridge_timer
  import mmio_bridge_pkg::*;
(
  input  logic        cpuClk,
  input  logic        rst,
  input  logic        load_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] load_out,
  output logic [31:0] value_out,
  output logic [2:0]  ctrl_out,
  output logic        irq
);

  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        expired_q, expired_d;

  always_comb begin
    load_d    = load_q;
    value_d   = value_q;
    en_d      = en_q;
    ar_d      = ar_q;
    expired_d = expired_q;

    // Clear first so a simultaneous expiry below re-sets the flag.
    if (ctrl_we && wdata[CTRL_EXPIRED]) begin
      expired_d = 1'b0;
    end

    if (load_we) begin
      load_d  = wdata;
      value_d = wdata;
    end else if (en_q) begin
      if (value_q > 32'd1) begin
        value_d = value_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (ar_q) begin
          value_d = load_q;
        end else begin
          value_d = '0;
          en_d    = 1'b0;
        end
      end
    end

    if (ctrl_we) begin
      en_d = wdata[CTRL_EN];
      ar_d = wdata[CTRL_AUTORELOAD];
    end
  end

  always_ff @(posedge cpuClk or posedge rst) begin
    if (rst) begin
      load_q    <= '0;
      value_q   <= '0;
      en_q      <= 1'b0;
      ar_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      load_q    <= load_d;
      value_q   <= value_d;
      en_q      <= en_d;
      ar_q      <= ar_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    ctrl_out                  = '0;
    ctrl_out[CTRL_EN]         = en_q;
    ctrl_out[CTRL_AUTORELOAD] = ar_q;
    ctrl_out[CTRL_EXPIRED]    = expired_q;
  end

  assign load_out  = load_q;
  assign value_out = value_q;
  assign irq       = expired_q;

endmodule
`endif

// File: rtl/mmio_bridge.sv
// mmio_bridge: routes CPU loads/stores to RAM, board I/O registers or the timer.
// Define MMIO_TIMER_EN to build the timer; otherwise offsets 0x10-0x18 are unmapped.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int         RAM_ADDR_BITS  = 12,
  parameter logic [3:0] IO_BASE_NIBBLE = 4'hF,
  parameter int         SW_WIDTH       = 16
) (
  input  logic                cpuClk,
  input  logic                rst,
  input  logic [31:0]         cpuAddress,
  input  logic                cpuMemRead,
  input  logic                cpuMemWrite,
  input  logic [31:0]         cpuWriteData,
  output logic [31:0]         cpuReadData,
  output logic [31:0]         ramAddress,
  output logic                ramReadEnable,
  output logic                ramWriteEnable,
  output logic [31:0]         ramWriteData,
  input  logic [31:0]         ramReadData,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [7:0]          ledOut,
  output logic [31:0]         segOut,
  output logic                timerIrq,
  output logic                busError
);

  logic        ram_sel, io_sel, io_hit, unmapped;
  logic        led_we, seg_we;
  logic [31:0] io_rdata;

  logic [7:0]          led_q, led_d;
  logic [31:0]         seg_q, seg_d;
  logic [31:0]         cycle_q, cycle_d;
  logic [31:0]         io_rdata_q, io_rdata_d;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
  sel_e                sel_q, sel_d;
  logic                bus_error_q, bus_error_d;

`ifdef MMIO_TIMER_EN
  logic        load_we, ctrl_we, timer_irq;
  logic [31:0] timer_load, timer_value;
  logic [2:0]  timer_ctrl;
`endif

  // Address decode; bits [27:8] of an I/O address are don't-care.
  always_comb begin
    ram_sel  = (cpuAddress[31:RAM_ADDR_BITS] == '0);
    io_hit   = 1'b0;
    io_rdata = '0;
    case (cpuAddress[7:2])
      MMIO_LED[7:2]:   begin io_hit = 1'b1; io_rdata = {24'b0, led_q}; end
      MMIO_SEG[7:2]:   begin io_hit = 1'b1; io_rdata = seg_q; end
      MMIO_SW[7:2]:    begin io_hit = 1'b1; io_rdata = 32'(sw_sync_q); end
      MMIO_CYCLE[7:2]: begin io_hit = 1'b1; io_rdata = cycle_q; end
`ifdef MMIO_TIMER_EN
      MMIO_LOAD[7:2]:  begin io_hit = 1'b1; io_rdata = timer_load; end
      MMIO_CTRL[7:2]:  begin io_hit = 1'b1; io_rdata = 32'(timer_ctrl); end
      MMIO_VALUE[7:2]: begin io_hit = 1'b1; io_rdata = timer_value; end
`endif
      default: ;
    endcase
    io_sel   = !ram_sel && (cpuAddress[31:28] == IO_BASE_NIBBLE) && io_hit;
    unmapped = (cpuMemRead || cpuMemWrite) && !ram_sel && !io_sel;
    led_we   = cpuMemWrite && io_sel && (cpuAddress[7:2] == MMIO_LED[7:2]);
    seg_we   = cpuMemWrite && io_sel && (cpuAddress[7:2] == MMIO_SEG[7:2]);
  end

  always_comb begin
    led_d       = led_we ? cpuWriteData[7:0] : led_q;
    seg_d       = seg_we ? cpuWriteData : seg_q;
    cycle_d     = cycle_q + 32'd1;
    sw_meta_d   = sw;
    sw_sync_d   = sw_meta_q;
    bus_error_d = bus_error_q || unmapped;
    sel_d       = sel_q;
    io_rdata_d  = io_rdata_q;
    // Target and I/O data are captured on the read strobe and held until the next one.
    if (cpuMemRead) begin
      io_rdata_d = io_sel ? io_rdata : '0;
      if (ram_sel)     sel_d = SEL_RAM;
      else if (io_sel) sel_d = SEL_IO;
      else             sel_d = SEL_NONE;
    end
  end

  always_ff @(posedge cpuClk or posedge rst) begin
    if (rst) begin
      led_q       <= '0;
      seg_q       <= '0;
      cycle_q     <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      bus_error_q <= 1'b0;
      sel_q       <= SEL_NONE;
      io_rdata_q  <= '0;
    end else begin
      led_q       <= led_d;
      seg_q       <= seg_d;
      cycle_q     <= cycle_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      bus_error_q <= bus_error_d;
      sel_q       <= sel_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_RAM: cpuReadData = ramReadData;
      SEL_IO:  cpuReadData = io_rdata_q;
      default: cpuReadData = '0;
    endcase
  end

  assign ramAddress     = cpuAddress;
  assign ramWriteData   = cpuWriteData;
  assign ramReadEnable  = cpuMemRead && ram_sel;
  assign ramWriteEnable = cpuMemWrite && ram_sel;
  assign ledOut         = led_q;
  assign segOut         = seg_q;
  assign busError       = bus_error_q;

`ifdef MMIO_TIMER_EN
  assign load_we = cpuMemWrite && io_sel && (cpuAddress[7:2] == MMIO_LOAD[7:2]);
  assign ctrl_we = cpuMemWrite && io_sel && (cpuAddress[7:2] == MMIO_CTRL[7:2]);

  mmio_bridge_timer u_timer (
    .cpuClk    (cpuClk),
    .rst       (rst),
    .load_we   (load_we),
    .ctrl_we   (ctrl_we),
    .wdata     (cpuWriteData),
    .load_out  (timer_load),
    .value_out (timer_value),
    .ctrl_out  (timer_ctrl),
    .irq       (timer_irq)
  );

  assign timerIrq = timer_irq;
`else
  assign timerIrq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: vector table, random traffic against a
// reference model, and hand-written reset/timer sequences (timer under MMIO_TIMER_EN).
module tb_mmio_bridge;

  logic        cpuClk;
  logic        rst;
  logic [31:0] cpuAddress;
  logic        cpuMemRead;
  logic        cpuMemWrite;
  logic [31:0] cpuWriteData;
  logic [31:0] cpuReadData;
  logic [31:0] ramAddress;
  logic        ramReadEnable;
  logic        ramWriteEnable;
  logic [31:0] ramWriteData;
  logic [31:0] ramReadData;
  logic [15:0] sw;
  logic [7:0]  ledOut;
  logic [31:0] segOut;
  logic        timerIrq;
  logic        busError;

  int checks = 0;
  int errors = 0;

  mmio_bridge dut (
    .cpuClk         (cpuClk),
    .rst            (rst),
    .cpuAddress     (cpuAddress),
    .cpuMemRead     (cpuMemRead),
    .cpuMemWrite    (cpuMemWrite),
    .cpuWriteData   (cpuWriteData),
    .cpuReadData    (cpuReadData),
    .ramAddress     (ramAddress),
    .ramReadEnable  (ramReadEnable),
    .ramWriteEnable (ramWriteEnable),
    .ramWriteData   (ramWriteData),
    .ramReadData    (ramReadData),
    .sw             (sw),
    .ledOut         (ledOut),
    .segOut         (segOut),
    .timerIrq       (timerIrq),
    .busError       (busError)
  );

  initial cpuClk = 1'b0;
  always #5 cpuClk = ~cpuClk;

  // Stand-in for Ram32b: 4 KiB, one-cycle registered read, cleared by reset.
  logic [31:0] ram_mem [1024];
  always @(posedge cpuClk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
      ramReadData <= '0;
    end else begin
      if (ramWriteEnable) ram_mem[ramAddress[11:2]] <= ramWriteData;
      if (ramReadEnable)  ramReadData <= ram_mem[ramAddress[11:2]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge cpuClk);
    #1;
  endtask

  // One bus transaction; read data is the value visible the cycle after the strobe.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata);
    logic is_ram;
    is_ram       = (addr[31:12] == 20'h0);
    cpuAddress   = addr;
    cpuMemRead   = rd;
    cpuMemWrite  = wr;
    cpuWriteData = wd;
    #1;
    check("ram_read_enable",  {31'b0, ramReadEnable},  {31'b0, rd & is_ram});
    check("ram_write_enable", {31'b0, ramWriteEnable}, {31'b0, wr & is_ram});
    @(posedge cpuClk);
    #1;
    cpuMemRead  = 1'b0;
    cpuMemWrite = 1'b0;
    rdata = cpuReadData;
    $display("txn rd=%0d wr=%0d addr=%08h wdata=%08h rdata=%08h", rd, wr, addr, wd, rdata);
  endtask

  task automatic do_reset();
    cpuAddress   = '0;
    cpuMemRead   = 1'b0;
    cpuMemWrite  = 1'b0;
    cpuWriteData = '0;
    rst = 1'b1;
    #1;
    check("rst_cpuReadData", cpuReadData, 32'h0);
    check("rst_ramAddress", ramAddress, 32'h0);
    check("rst_ramWriteData", ramWriteData, 32'h0);
    check("rst_ram_enables", {30'b0, ramReadEnable, ramWriteEnable}, 32'h0);
    check("rst_ledOut", {24'b0, ledOut}, 32'h0);
    check("rst_segOut", segOut, 32'h0);
    check("rst_timerIrq", {31'b0, timerIrq}, 32'h0);
    check("rst_busError", {31'b0, busError}, 32'h0);
    @(posedge cpuClk);
    #1;
    rst = 1'b0;
    $display("txn reset");
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  logic [31:0] ram_ref [1024];
  logic [7:0]  led_ref;
  logic [31:0] seg_ref;

  initial begin
    logic [31:0] rdata, c1, c2, addr, wd, exp;
    int kind, op, w;

    vecs[0]  = '{1'b0, 1'b1, 32'hF000_0000, 32'h0000_00A5, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'hF000_0004, 32'h0000_BEEF, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'hF000_0000, 32'h0,         32'h0000_00A5};
    vecs[3]  = '{1'b1, 1'b0, 32'hF000_0006, 32'h0,         32'h0000_BEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678};
    vecs[6]  = '{1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_FF3C, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'hF000_0000, 32'h0,         32'h0000_003C};
    vecs[8]  = '{1'b1, 1'b1, 32'hF000_0004, 32'h1111_2222, 32'h0000_BEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'hF000_0004, 32'h0,         32'h1111_2222};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 1'b1, 32'hF0AB_CD00, 32'h0000_0077, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'hF000_0000, 32'h0,         32'h0000_0077};

    sw = 16'h0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, rdata);
      if (vecs[i].rd) check($sformatf("vec%0d_read", i), rdata, vecs[i].exp_rd);
    end
    check("ledOut_after_vecs", {24'b0, ledOut}, 32'h0000_0077);
    check("segOut_after_vecs", segOut, 32'h1111_2222);
    check("busError_clean", {31'b0, busError}, 32'h0);

    // Switch synchronizer: two edges of latency before a load sees a new value.
    sw = 16'h00FF;
    idle(2);
    access(1'b1, 1'b0, 32'hF000_0008, 32'h0, rdata);
    check("sw_00ff", rdata, 32'h0000_00FF);
    sw = 16'h1234;
    access(1'b1, 1'b0, 32'hF000_0008, 32'h0, rdata);
    check("sw_not_yet_synced", rdata, 32'h0000_00FF);
    idle(1);
    access(1'b1, 1'b0, 32'hF000_0008, 32'h0, rdata);
    check("sw_synced", rdata, 32'h0000_1234);

    // Cycle counter: first strobe edge after reset samples 0; strobes 5 edges apart differ by 5.
    do_reset();
    access(1'b1, 1'b0, 32'hF000_000C, 32'h0, c1);
    check("cycle_after_reset", c1, 32'h0);
    idle(4);
    access(1'b1, 1'b0, 32'hF000_000C, 32'h0, c2);
    check("cycle_delta", c2 - c1, 32'd5);

    // Unmapped accesses and the sticky bus error.
    access(1'b1, 1'b0, 32'h8000_0000, 32'h0, rdata);
    check("unmapped_read_data", rdata, 32'h0);
    check("busError_set", {31'b0, busError}, 32'h1);
    access(1'b0, 1'b1, 32'hF000_0000, 32'h0000_005A, rdata);
    check("busError_sticky", {31'b0, busError}, 32'h1);
    check("led_after_error", {24'b0, ledOut}, 32'h0000_005A);
    do_reset();
    access(1'b0, 1'b1, 32'h0000_1000, 32'h5555_5555, rdata);
    check("ram_edge_unmapped", {31'b0, busError}, 32'h1);
    do_reset();
    access(1'b1, 1'b0, 32'hF000_001C, 32'h0, rdata);
    check("io_hole_read", rdata, 32'h0);
    check("io_hole_busError", {31'b0, busError}, 32'h1);
    do_reset();
`ifdef MMIO_TIMER_EN
    access(1'b1, 1'b0, 32'hF000_0010, 32'h0, rdata);
    check("load_reset_read", rdata, 32'h0);
    check("load_mapped", {31'b0, busError}, 32'h0);
`else
    access(1'b1, 1'b0, 32'hF000_0010, 32'h0, rdata);
    check("no_timer_load_read", rdata, 32'h0);
    check("no_timer_busError", {31'b0, busError}, 32'h1);
    access(1'b1, 1'b0, 32'hF000_0018, 32'h0, rdata);
    check("no_timer_value_read", rdata, 32'h0);
    check("no_timer_irq", {31'b0, timerIrq}, 32'h0);
`endif

    // Reset during a pending read drops it.
    do_reset();
    access(1'b0, 1'b1, 32'hF000_0000, 32'h0000_00A5, rdata);
    cpuAddress = 32'hF000_0000;
    cpuMemRead = 1'b1;
    @(posedge cpuClk);
    #1;
    cpuMemRead = 1'b0;
    check("read_before_reset", cpuReadData, 32'h0000_00A5);
    rst = 1'b1;
    #1;
    check("read_dropped_in_reset", cpuReadData, 32'h0);
    check("led_cleared_in_reset", {24'b0, ledOut}, 32'h0);
    @(posedge cpuClk);
    #1;
    rst = 1'b0;
    idle(1);
    check("read_dropped_after_reset", cpuReadData, 32'h0);
    $display("txn reset_mid_access");

`ifdef MMIO_TIMER_EN
    // One-shot: LOAD=3, enable; expires on the third counting edge.
    do_reset();
    access(1'b0, 1'b1, 32'hF000_0010, 32'd3, rdata);
    access(1'b0, 1'b1, 32'hF000_0014, 32'h1, rdata);
    idle(2);
    check("oneshot_irq_early", {31'b0, timerIrq}, 32'h0);
    idle(1);
    check("oneshot_irq", {31'b0, timerIrq}, 32'h1);
    access(1'b1, 1'b0, 32'hF000_0014, 32'h0, rdata);
    check("oneshot_ctrl", rdata, 32'h4);
    access(1'b1, 1'b0, 32'hF000_0018, 32'h0, rdata);
    check("oneshot_value", rdata, 32'h0);
    access(1'b0, 1'b1, 32'hF000_0014, 32'h4, rdata);
    check("irq_cleared", {31'b0, timerIrq}, 32'h0);
    // Autoreload from VALUE=0: expires on the first counting edge and reloads LOAD.
    access(1'b0, 1'b1, 32'hF000_0014, 32'h3, rdata);
    idle(1);
    check("autoreload_irq", {31'b0, timerIrq}, 32'h1);
    access(1'b1, 1'b0, 32'hF000_0018, 32'h0, rdata);
    check("autoreload_value", rdata, 32'd3);
    access(1'b1, 1'b0, 32'hF000_0014, 32'h0, rdata);
    check("autoreload_ctrl", rdata, 32'h7);
    // Reset mid-count clears every timer register.
    access(1'b0, 1'b1, 32'hF000_0010, 32'd100, rdata);
    access(1'b0, 1'b1, 32'hF000_0014, 32'h1, rdata);
    idle(5);
    do_reset();
    access(1'b1, 1'b0, 32'hF000_0010, 32'h0, rdata);
    check("rst_load", rdata, 32'h0);
    access(1'b1, 1'b0, 32'hF000_0014, 32'h0, rdata);
    check("rst_ctrl", rdata, 32'h0);
    access(1'b1, 1'b0, 32'hF000_0018, 32'h0, rdata);
    check("rst_value", rdata, 32'h0);
`endif

    // Random traffic against a plain reference model of RAM, LED and SEG.
    do_reset();
    for (int i = 0; i < 1024; i++) ram_ref[i] = '0;
    led_ref = '0;
    seg_ref = '0;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      op   = $urandom_range(0, 2);
      w    = $urandom_range(0, 1023);
      wd   = $urandom;
      case (kind)
        0:       begin addr = 32'(w) << 2; exp = ram_ref[w]; end
        1:       begin addr = 32'hF000_0000 | 32'($urandom_range(0, 3)); exp = {24'b0, led_ref}; end
        default: begin addr = 32'hF000_0004 | 32'($urandom_range(0, 3)); exp = seg_ref; end
      endcase
      access(op != 1, op != 0, addr, wd, rdata);
      if (op != 1) check($sformatf("rand%0d_read", n), rdata, exp);
      if (op != 0) begin
        case (kind)
          0:       ram_ref[w] = wd;
          1:       led_ref = wd[7:0];
          default: seg_ref = wd;
        endcase
      end
    end
    check("rand_ledOut", {24'b0, ledOut}, {24'b0, led_ref});
    check("rand_segOut", segOut, seg_ref);
    check("rand_busError", {31'b0, busError}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
